// File: rtl/cpu_stream_arbiter.sv
// Round-robin merge of NUM_CPU request streams onto one registered output word,
// tagging each word with its source CPU and per-CPU transaction index.
module cpu_stream_arbiter #(
  parameter int NUM_CPU     = 16,
  parameter int DATA_W      = 64,
  parameter int TXN_PER_CPU = 1000,
  parameter int IDX_W       = (NUM_CPU > 1) ? $clog2(NUM_CPU) : 1,
  parameter int CNT_W       = $clog2(TXN_PER_CPU + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CPU-1:0]        req_vld,
  input  logic [NUM_CPU*DATA_W-1:0] req_data,
  output logic [NUM_CPU-1:0]        req_rdy,
  output logic                      out_vld,
  output logic [DATA_W-1:0]         out_data,
  output logic [IDX_W-1:0]          out_cpu_idx,
  output logic [CNT_W-1:0]          out_txn_idx,
  input  logic                      out_rdy,
  output logic [NUM_CPU-1:0]        cpu_done,
  output logic                      all_done
);

  logic [NUM_CPU-1:0] eligible_p0;
  logic               load_ok_p0;
  logic               gnt_found_p0;
  logic               xfer_p0;
  logic [IDX_W-1:0]   gnt_idx_p0;
  logic [IDX_W-1:0]   rr_next_p0;
  logic [DATA_W-1:0]  gnt_data_p0;
  logic [CNT_W-1:0]   gnt_cnt_p0;
  logic [IDX_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   cnt [NUM_CPU];

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return (v >= NUM_CPU) ? IDX_W'(v - NUM_CPU) : IDX_W'(v);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(TXN_PER_CPU)) ? c : c + CNT_W'(1);
  endfunction

  // Stage p0: combinational grant, searching from rr_ptr upward with wrap
  always_comb begin
    eligible_p0  = req_vld & ~cpu_done;
    load_ok_p0   = !out_vld || out_rdy;
    gnt_found_p0 = 1'b0;
    gnt_idx_p0   = '0;
    // Scan farthest-first so the candidate closest to rr_ptr wins last.
    for (int k = NUM_CPU - 1; k >= 0; k--) begin
      if (eligible_p0[wrap_idx(int'(rr_ptr) + k)]) begin
        gnt_found_p0 = 1'b1;
        gnt_idx_p0   = wrap_idx(int'(rr_ptr) + k);
      end
    end
    xfer_p0 = load_ok_p0 && gnt_found_p0 && !rst;
    req_rdy = '0;
    if (xfer_p0) req_rdy[gnt_idx_p0] = 1'b1;
    gnt_data_p0 = req_data[int'(gnt_idx_p0) * DATA_W +: DATA_W];
    gnt_cnt_p0  = cnt[gnt_idx_p0];
    rr_next_p0  = wrap_idx(int'(gnt_idx_p0) + 1);
  end

  // Stage p1: output register, per-CPU counters and retirement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld     <= 1'b0;
      out_data    <= '0;
      out_cpu_idx <= '0;
      out_txn_idx <= '0;
      cpu_done    <= '0;
      all_done    <= 1'b0;
      rr_ptr      <= '0;
      for (int i = 0; i < NUM_CPU; i++) cnt[i] <= '0;
    end else begin
      if (xfer_p0) begin
        out_vld          <= 1'b1;
        out_data         <= gnt_data_p0;
        out_cpu_idx      <= gnt_idx_p0;
        out_txn_idx      <= gnt_cnt_p0;
        cnt[gnt_idx_p0]  <= sat_inc(gnt_cnt_p0);
        if (gnt_cnt_p0 + CNT_W'(1) == CNT_W'(TXN_PER_CPU)) cpu_done[gnt_idx_p0] <= 1'b1;
        rr_ptr           <= rr_next_p0;
      end else if (out_vld && out_rdy) begin
        out_vld <= 1'b0;
      end
      // Sticky: only rises once the final word has left the output register.
      if (&cpu_done && !out_vld) all_done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_stream_arbiter.sv
// Bench for cpu_stream_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-free behavioural model of the arbiter.
module tb_cpu_stream_arbiter;
  localparam int N   = 16;
  localparam int DW  = 64;
  localparam int TXN = 8;
  localparam int IW  = 4;
  localparam int CW  = $clog2(TXN + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_vld;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_rdy;
  logic              out_vld;
  logic [DW-1:0]     out_data;
  logic [IW-1:0]     out_cpu_idx;
  logic [CW-1:0]     out_txn_idx;
  logic              out_rdy;
  logic [N-1:0]      cpu_done;
  logic              all_done;

  int n_vec = 0;
  int n_err = 0;

  // Model state
  int          m_cnt [N];
  logic [N-1:0] m_done;
  int          m_ptr;
  bit          m_vld;
  logic [DW-1:0] m_data;
  int          m_cpu;
  int          m_txn;
  bit          m_all;

  cpu_stream_arbiter #(.NUM_CPU(N), .DATA_W(DW), .TXN_PER_CPU(TXN)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data), .req_rdy(req_rdy),
    .out_vld(out_vld), .out_data(out_data), .out_cpu_idx(out_cpu_idx),
    .out_txn_idx(out_txn_idx), .out_rdy(out_rdy), .cpu_done(cpu_done), .all_done(all_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int m_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_vld[i] && !m_done[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_vld = 0; m_all = 0; m_done = '0;
    m_data = '0; m_cpu = 0; m_txn = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_edge();
    int w;
    bit load;
    bit all_prev;
    all_prev = (m_done == {N{1'b1}}) && !m_vld;
    load = !m_vld || out_rdy;
    w = m_winner();
    if (load && w >= 0) begin
      m_vld  = 1;
      m_data = req_data[w*DW +: DW];
      m_cpu  = w;
      m_txn  = m_cnt[w];
      m_cnt[w]++;
      if (m_cnt[w] == TXN) m_done[w] = 1'b1;
      m_ptr = (w + 1) % N;
    end else if (m_vld && out_rdy) begin
      m_vld = 0;
    end
    if (all_prev) m_all = 1;
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge.
  task automatic step();
    int w;
    logic [N-1:0] exp_rdy;
    #1;
    w = m_winner();
    exp_rdy = '0;
    if ((!m_vld || out_rdy) && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
    @(posedge clk);
    model_edge();
    #1;
    chk("out_vld", 64'(out_vld), 64'(m_vld));
    if (m_vld) begin
      chk("out_data", out_data, m_data);
      chk("out_cpu_idx", 64'(out_cpu_idx), 64'(m_cpu));
      chk("out_txn_idx", 64'(out_txn_idx), 64'(m_txn));
    end
    chk("cpu_done", 64'(cpu_done), 64'(m_done));
    chk("all_done", 64'(all_done), 64'(m_all));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] held;
    req_vld = '0; req_data = '0; out_rdy = 1'b0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_req_rdy", 64'(req_rdy), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_cpu_done", 64'(cpu_done), 64'd0);
    chk("rst_all_done", 64'(all_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // All CPUs requesting: strict rotation 0..15 then 0 again
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 64'(i);
    req_vld = '1; out_rdy = 1'b1;
    for (int k = 0; k < 17; k++) begin
      #1;
      chk("t1_grant", 64'(req_rdy), 64'(1) << (k % N));
      step();
      chk("t1_cpu", 64'(out_cpu_idx), 64'(k % N));
      chk("t1_txn", 64'(out_txn_idx), 64'(k / N));
      chk("t1_data", out_data, 64'(k % N));
    end
    req_vld = '0;
    step(); step();

    // Single requester CPU5 runs to retirement
    req_data[5*DW +: DW] = 64'hDEADBEEF_00000005;
    req_vld = N'(1) << 5;
    for (int k = 0; k < 10; k++) step();
    chk("t2_done5", 64'(cpu_done[5]), 64'd1);
    #1;
    chk("t2_rdy_retired", 64'(req_rdy), 64'd0);
    chk("t2_all_done", 64'(all_done), 64'd0);
    @(negedge clk);

    // CPUs 2 and 9 with a 4-cycle consumer stall
    do_reset();
    req_vld = (N'(1) << 2) | (N'(1) << 9);
    out_rdy = 1'b1;
    step();
    chk("t3_first", 64'(out_cpu_idx), 64'd2);
    held = out_data;
    out_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t3_hold_cpu", 64'(out_cpu_idx), 64'd2);
      chk("t3_hold_data", out_data, held);
      chk("t3_hold_vld", 64'(out_vld), 64'd1);
      #1;
      chk("t3_hold_rdy", 64'(req_rdy), 64'd0);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    step();
    chk("t3_next9", 64'(out_cpu_idx), 64'd9);
    step();
    chk("t3_then2", 64'(out_cpu_idx), 64'd2);

    // Asynchronous reset with a word pending and cnt[3]=7
    do_reset();
    req_vld = N'(1) << 3;
    for (int k = 0; k < 7; k++) step();
    chk("t4_pre_txn", 64'(out_txn_idx), 64'd6);
    chk("t4_pre_vld", 64'(out_vld), 64'd1);
    rst = 1'b1;
    #1;
    chk("t4_async_vld", 64'(out_vld), 64'd0);
    chk("t4_async_done", 64'(cpu_done), 64'd0);
    chk("t4_rst_rdy", 64'(req_rdy), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    req_vld = (N'(1) << 3) | (N'(1) << 5);
    step();
    chk("t4_cpu", 64'(out_cpu_idx), 64'd3);
    chk("t4_txn", 64'(out_txn_idx), 64'd0);

    // Idle period leaves the pointer alone
    req_vld = '0;
    for (int k = 0; k < 20; k++) step();
    chk("t5_idle_vld", 64'(out_vld), 64'd0);
    req_vld = N'(1) << 7;
    #1;
    chk("t5_grant7", 64'(req_rdy), 64'(1) << 7);
    step();
    chk("t5_cpu7", 64'(out_cpu_idx), 64'd7);

    // Random traffic until every CPU retires
    for (int c = 0; c < 2000 && !m_all; c++) begin
      req_vld = N'($urandom);
      out_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
      step();
    end
    chk("t6_all_done", 64'(all_done), 64'd1);
    for (int c = 0; c < 8; c++) begin
      req_vld = N'($urandom);
      out_rdy = $urandom_range(0, 1) == 1;
      step();
    end
    chk("t6_all_done_sticky", 64'(all_done), 64'd1);
    chk("t6_all_cpu_done", 64'(cpu_done), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
